// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: FSM encodings, arbitration modes and the default CPU memory map.
// Latency: none (types and constants only).
// Backpressure: n/a.
package cpu_bus_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK    = 32'hFFFF_0000;
    localparam logic [31:0] SDRAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] SDRAM_MASK  = 32'hFC00_0000;
    localparam logic [31:0] TERM_BASE   = 32'h2000_0000;
    localparam logic [31:0] TERM_MASK   = 32'hFFFF_E000;
    localparam logic [31:0] SYSREG_BASE = 32'h4000_0000;
    localparam logic [31:0] SYSREG_MASK = 32'hFFFF_FF00;

    // Unused slots: word-aligned addresses never have both low bits set, so this never hits.
    localparam logic [31:0] NO_HIT = 32'hFFFF_FFFF;

    // Eight slots so any NUM_SLAVES in 1..8 can slice its default map from the bottom.
    localparam logic [255:0] MAP_BASE = {{4{NO_HIT}}, SYSREG_BASE, TERM_BASE, SDRAM_BASE, RAM_BASE};
    localparam logic [255:0] MAP_MASK = {{4{NO_HIT}}, SYSREG_MASK, TERM_MASK, SDRAM_MASK, RAM_MASK};

    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/cpu_bus_fabric_if.sv
// cpu_bus_fabric_if: Wishbone master ports plus the shared valid/ready slave bus.
// Latency: none (wires only).
// Backpressure: masters hold CYC/STB until ACK/ERR; slave valid is held until ready.
// The fabric is the Wishbone slave of the CPU ports, so it uses modport "slave";
// the surrounding CPU masters and memory slaves together use modport "master".
interface cpu_bus_fabric_if #(
    parameter int NM = 2,
    parameter int NS = 4
);
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_we;
    logic [NM*30-1:0] m_adr;
    logic [NM*32-1:0] m_dat_mosi;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [NM*32-1:0] m_dat_miso;
    logic [NS-1:0]    s_valid;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]    s_ready;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel,
        output m_ack, m_err, m_dat_miso,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ready
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_mosi, m_sel,
        input  m_ack, m_err, m_dat_miso,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ready
    );

endinterface

// File: rtl/cpu_bus_rr_arbiter.sv
// cpu_bus_rr_arbiter: fixed-priority (highest index) or round-robin grant over the request vector.
// Latency: combinational grant; round-robin pointer updates on the edge that takes a grant.
// Backpressure: none; the caller only advances when it actually accepts a request.
module cpu_bus_rr_arbiter import cpu_bus_pkg::*; #(
    parameter int NM   = 2,
    parameter int MODE = ARB_FIXED,
    localparam int IW  = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NM-1:0] req,
    input  logic          advance,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] ptr;

    function automatic int wrap(input int v);
        return (v >= NM) ? v - NM : v;
    endfunction

    // Select the winner; loops run so the preferred candidate is written last.
    always_comb begin
        grant_idx = '0;
        grant     = '0;
        any_req   = |req;
        if (MODE == ARB_RR) begin
            for (int k = NM - 1; k >= 0; k--) begin
                if (req[wrap(int'(ptr) + k)]) grant_idx = IW'(wrap(int'(ptr) + k));
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (req[i]) grant_idx = IW'(i);
            end
        end
        grant[grant_idx] = any_req;
    end

    // Round-robin pointer moves to the slot after the master just granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (MODE == ARB_RR && advance && any_req) begin
            ptr <= (grant_idx == IW'(NM - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: N Wishbone masters arbitrated onto one decoded valid/ready slave bus (BUS_TIMEOUT_EN adds an access timeout).
// Latency: request to s_valid 1 cycle, s_ready to ACK 1 cycle; unmapped ERR 1 cycle after request.
// Backpressure: one transfer in flight; other masters wait with CYC/STB held; s_valid held until s_ready.
module cpu_bus_fabric import cpu_bus_pkg::*; #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int ARB_MODE       = ARB_FIXED,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = MAP_BASE[NUM_SLAVES*32-1:0],
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = MAP_MASK[NUM_SLAVES*32-1:0],
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset,
    cpu_bus_fabric_if.slave bus
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || NUM_SLAVES < 1 || NUM_SLAVES > 8 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cpu_bus_fabric: parameter out of range");
    end

    logic [0:0]             state;
    logic [IW-1:0]          gnt;
    logic [SW-1:0]          slv;
    logic                   is_write;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   cur_we;
    logic [31:0]            req_addr;
    logic [NUM_SLAVES-1:0]  hit_vec;
    logic [SW-1:0]          hit_idx;
    logic                   hit_any;
    logic                   to_expire;

    // The acknowledged master is masked for one cycle so its dropped STB is never re-granted.
    assign req = bus.m_cyc & bus.m_stb & ~bus.m_ack & ~bus.m_err;

    cpu_bus_rr_arbiter #(
        .NM   (NUM_MASTERS),
        .MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (state == ST_IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign cur_we   = |(bus.m_we & arb_grant);
    assign req_addr = {bus.m_adr[int'(arb_idx)*30 +: 30], 2'b00};

    // Address decode of the candidate master; lowest slave index wins overlapping windows.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        hit_any = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (win_hit(req_addr, SLAVE_BASE[k*32 +: 32], SLAVE_MASK[k*32 +: 32])) begin
                hit_idx = SW'(k);
                hit_any = 1'b1;
            end
        end
        hit_vec[hit_idx] = hit_any;
    end

`ifdef BUS_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign to_expire = (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles without ready; cleared whenever the fabric is not waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS && !bus.s_ready[slv] && !to_expire) begin
            to_cnt <= to_cnt + 32'd1;
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    // Transfer FSM: grant and decode in IDLE, wait for the selected slave in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            gnt            <= '0;
            slv            <= '0;
            is_write       <= 1'b0;
            bus.m_ack      <= '0;
            bus.m_err      <= '0;
            bus.m_dat_miso <= '0;
            bus.s_valid    <= '0;
            bus.s_addr     <= '0;
            bus.s_wdata    <= '0;
            bus.s_wstrb    <= '0;
        end else begin
            bus.m_ack <= '0;
            bus.m_err <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt         <= arb_idx;
                        is_write    <= cur_we;
                        bus.s_addr  <= req_addr;
                        bus.s_wdata <= bus.m_dat_mosi[int'(arb_idx)*32 +: 32];
                        bus.s_wstrb <= cur_we ? bus.m_sel[int'(arb_idx)*4 +: 4] : 4'b0000;
                        if (hit_any) begin
                            bus.s_valid <= hit_vec;
                            slv         <= hit_idx;
                            state       <= ST_ACCESS;
                        end else begin
                            bus.m_err[arb_idx]                      <= 1'b1;
                            bus.m_dat_miso[int'(arb_idx)*32 +: 32] <= '0;
                        end
                    end
                end
                default: begin
                    if (bus.s_ready[slv]) begin
                        bus.m_ack[gnt]                      <= 1'b1;
                        bus.m_dat_miso[int'(gnt)*32 +: 32] <= is_write ? 32'h0 : bus.s_rdata[int'(slv)*32 +: 32];
                        bus.s_valid                         <= '0;
                        state                               <= ST_IDLE;
                    end else if (to_expire) begin
                        bus.m_err[gnt]                      <= 1'b1;
                        bus.m_dat_miso[int'(gnt)*32 +: 32] <= '0;
                        bus.s_valid                         <= '0;
                        state                               <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb_cpu_bus_fabric: directed vectors against a 2-master fixed-priority fabric and a 3-master round-robin one.
// Latency: checks request->s_valid 1 cycle, ready->ACK 1 cycle, unmapped ERR 1 cycle.
// Backpressure: slave ready delays, held requests during ACCESS, reset during ACCESS.
module tb_cpu_bus_fabric;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cpu_bus_fabric_if #(.NM(2), .NS(4)) bus0 ();
    cpu_bus_fabric_if #(.NM(3), .NS(4)) bus1 ();

    cpu_bus_fabric #(.NUM_MASTERS(2), .NUM_SLAVES(4), .ARB_MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk (clk), .reset (reset), .bus (bus0)
    );
    cpu_bus_fabric #(.NUM_MASTERS(3), .NUM_SLAVES(4), .ARB_MODE(1), .TIMEOUT_CYCLES(16)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [29:0] adr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          wait_cyc;   // ACCESS cycles before the target raises ready
        logic [31:0] rdata;
        logic [3:0]  noise;      // ready asserted by non-selected slaves
        logic        exp_err;
        logic [3:0]  exp_sv;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_miso;
    } vec_t;

    vec_t vecs[9];
    vec_t v;
    int   got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          port we  adr             wdata          sel   wt rdata          noise   err  sv      addr           wstrb    miso
        vecs[0] = '{0, 1'b0, 30'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 4'b0000, 1'b0, 4'b0001, 32'h0000_0040, 4'b0000, 32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 30'h0400_0000, 32'hCAFE_F00D, 4'h3, 6, 32'h1234_5678, 4'b0100, 1'b0, 4'b0010, 32'h1000_0000, 4'b0011, 32'h0};
        vecs[2] = '{0, 1'b0, 30'h0C00_0000, 32'h0,         4'hF, 0, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'h3000_0000, 4'b0000, 32'h0};
        vecs[3] = '{1, 1'b0, 30'h0800_07FF, 32'h0,         4'hF, 2, 32'h0000_00A5, 4'b1001, 1'b0, 4'b0100, 32'h2000_1FFC, 4'b0000, 32'h0000_00A5};
        vecs[4] = '{0, 1'b0, 30'h0800_0800, 32'h0,         4'hF, 0, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'h2000_2000, 4'b0000, 32'h0};
        vecs[5] = '{1, 1'b0, 30'h1000_003F, 32'h0,         4'hF, 1, 32'h5A5A_0001, 4'b0011, 1'b0, 4'b1000, 32'h4000_00FC, 4'b0000, 32'h5A5A_0001};
        vecs[6] = '{0, 1'b1, 30'h0000_3FFF, 32'h1122_3344, 4'hC, 0, 32'hFFFF_FFFF, 4'b0000, 1'b0, 4'b0001, 32'h0000_FFFC, 4'b1100, 32'h0};
        vecs[7] = '{0, 1'b0, 30'h04FF_FFFF, 32'h0,         4'hF, 0, 32'h0BAD_CAFE, 4'b0001, 1'b0, 4'b0010, 32'h13FF_FFFC, 4'b0000, 32'h0BAD_CAFE};
        vecs[8] = '{1, 1'b0, 30'h1000_0040, 32'h0,         4'hF, 0, 32'h0,         4'b0000, 1'b1, 4'b0000, 32'h4000_0100, 4'b0000, 32'h0};

        bus0.m_cyc = '0; bus0.m_stb = '0; bus0.m_we = '0; bus0.m_adr = '0;
        bus0.m_dat_mosi = '0; bus0.m_sel = '0; bus0.s_rdata = '0; bus0.s_ready = '0;
        bus1.m_cyc = '0; bus1.m_stb = '0; bus1.m_we = '0; bus1.m_adr = '0;
        bus1.m_dat_mosi = '0; bus1.m_sel = '0; bus1.s_rdata = '0; bus1.s_ready = '0;

        // Reset state
        step(); step();
        chk("rst_ack", bus0.m_ack, 0);
        chk("rst_err", bus0.m_err, 0);
        chk("rst_miso", bus0.m_dat_miso, 0);
        chk("rst_s_valid", bus0.s_valid, 0);
        chk("rst_s_addr", bus0.s_addr, 0);
        chk("rst_s_wdata", bus0.s_wdata, 0);
        chk("rst_s_wstrb", bus0.s_wstrb, 0);
        chk("rst1_s_valid", bus1.s_valid, 0);
        reset = 1'b0;
        step();

        // Table of single transfers on the fixed-priority fabric
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            for (int k = 0; k < 4; k++)
                bus0.s_rdata[k*32 +: 32] = v.exp_sv[k] ? v.rdata : (32'hEE00_0000 | 32'(k));
            bus0.s_ready = v.noise;
            bus0.m_cyc[v.port] = 1'b1;
            bus0.m_stb[v.port] = 1'b1;
            bus0.m_we[v.port]  = v.we;
            bus0.m_adr[v.port*30 +: 30]      = v.adr;
            bus0.m_dat_mosi[v.port*32 +: 32] = v.wdata;
            bus0.m_sel[v.port*4 +: 4]        = v.sel;
            step();
            if (v.exp_err) begin
                chk($sformatf("v%0d_err", i), bus0.m_err, 64'(1) << v.port);
                chk($sformatf("v%0d_err_ack", i), bus0.m_ack, 0);
                chk($sformatf("v%0d_err_sv", i), bus0.s_valid, 0);
                chk($sformatf("v%0d_err_miso", i), bus0.m_dat_miso[v.port*32 +: 32], 0);
            end else begin
                chk($sformatf("v%0d_sv", i), bus0.s_valid, v.exp_sv);
                chk($sformatf("v%0d_addr", i), bus0.s_addr, v.exp_addr);
                chk($sformatf("v%0d_wdata", i), bus0.s_wdata, v.wdata);
                chk($sformatf("v%0d_wstrb", i), bus0.s_wstrb, v.exp_wstrb);
                for (int w = 0; w < v.wait_cyc; w++) begin
                    step();
                    chk($sformatf("v%0d_hold%0d", i, w), {bus0.s_valid, bus0.m_ack, bus0.s_addr},
                        {v.exp_sv, 2'b00, v.exp_addr});
                end
                bus0.s_ready = v.noise | v.exp_sv;
                step();
                chk($sformatf("v%0d_ack", i), bus0.m_ack, 64'(1) << v.port);
                chk($sformatf("v%0d_sv_drop", i), bus0.s_valid, 0);
                chk($sformatf("v%0d_miso", i), bus0.m_dat_miso[v.port*32 +: 32], v.exp_miso);
            end
            bus0.m_cyc = '0; bus0.m_stb = '0; bus0.m_we = '0; bus0.s_ready = '0;
            step();
            chk($sformatf("v%0d_pulse", i), {bus0.m_ack, bus0.m_err}, 0);
            chk($sformatf("v%0d_miso_hold", i), bus0.m_dat_miso[v.port*32 +: 32], v.exp_miso);
        end

        // Fixed priority: simultaneous requests, port 1 first, port 0 at the next grant
        bus0.s_ready = 4'b0001;
        bus0.s_rdata[31:0] = 32'h1111_1111;
        bus0.m_adr = {30'h0000_0030, 30'h0000_0020};
        bus0.m_cyc = 2'b11; bus0.m_stb = 2'b11;
        step();
        chk("fp_first_addr", bus0.s_addr, 32'h0000_00C0);
        chk("fp_first_sv", bus0.s_valid, 4'b0001);
        step();
        chk("fp_first_ack", bus0.m_ack, 2'b10);
        chk("fp_first_miso", bus0.m_dat_miso[63:32], 32'h1111_1111);
        bus0.s_rdata[31:0] = 32'h2222_2222;
        step();
        chk("fp_second_addr", bus0.s_addr, 32'h0000_0080);
        chk("fp_second_noack", bus0.m_ack, 2'b00);
        step();
        chk("fp_second_ack", bus0.m_ack, 2'b01);
        chk("fp_second_miso", bus0.m_dat_miso[31:0], 32'h2222_2222);
        bus0.m_cyc = 2'b10; bus0.m_stb = 2'b10;
        step();
        chk("fp_third_addr", bus0.s_addr, 32'h0000_00C0);
        bus0.m_cyc = '0; bus0.m_stb = '0;
        step();
        chk("fp_third_ack", bus0.m_ack, 2'b10);
        bus0.s_ready = '0;
        step();

        // Round-robin: three ports requesting continuously
        bus1.s_ready = 4'b0001;
        bus1.m_adr = {30'h2, 30'h1, 30'h0};
        bus1.m_cyc = 3'b111; bus1.m_stb = 3'b111;
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            step();
            if (bus1.s_valid != '0) got.push_back(int'(bus1.s_addr >> 2));
        end
        chk("rr_grants", 64'(got.size()), 6);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("rr_order%0d", i), 64'(got[i]), 64'(i % 3));
        bus1.m_cyc = '0; bus1.m_stb = '0;
        step(); step();
        bus1.s_ready = '0;

        // Slave that never readies
        bus0.m_adr[29:0] = 30'h0400_0000;
        bus0.m_cyc = 2'b01; bus0.m_stb = 2'b01;
        step();
        chk("stall_sv", bus0.s_valid, 4'b0010);
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            step();
            chk($sformatf("to_hold%0d", c), {bus0.s_valid, bus0.m_err}, {4'b0010, 2'b00});
        end
        step();
        chk("to_err", bus0.m_err, 2'b01);
        chk("to_sv", bus0.s_valid, 0);
        chk("to_miso", bus0.m_dat_miso[31:0], 0);
        bus0.m_cyc = '0; bus0.m_stb = '0;
        step();
        bus0.m_cyc = 2'b01; bus0.m_stb = 2'b01;
        step();
        chk("stall2_sv", bus0.s_valid, 4'b0010);
`else
        for (int c = 1; c < 40; c++) begin
            step();
            chk($sformatf("wait_hold%0d", c), {bus0.s_valid, bus0.m_err, bus0.m_ack}, {4'b0010, 4'b0000});
        end
`endif

        // Asynchronous reset in the middle of ACCESS
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sv", bus0.s_valid, 0);
        chk("arst_addr", bus0.s_addr, 0);
        chk("arst_wstrb", bus0.s_wstrb, 0);
        chk("arst_miso", bus0.m_dat_miso, 0);
        chk("arst_ack_err", {bus0.m_ack, bus0.m_err}, 0);
        bus0.m_cyc = '0; bus0.m_stb = '0;
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("post_rst%0d", c), {bus0.s_valid, bus0.m_ack, bus0.m_err}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
